// File: rtl/memory_writeback.sv
// rtl/memory_writeback.sv - M-stage data-memory handshake with stall, timeout and W-stage register
module memory_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic        Cant_ByteM,
    input  logic [4:0]  RDM,
    input  logic [18:0] ALUResultM,
    input  logic [18:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [18:0] mem_addr,
    output logic [18:0] mem_wdata,
    input  logic [18:0] mem_rdata,
    input  logic        mem_ready,
    output logic        RegWriteW,
    output logic [4:0]  RDW,
    output logic [18:0] ResultW,
    output logic        StallM,
    output logic        mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        regwrite_acc_q, regwrite_acc_d;
    logic [4:0]  rd_acc_q, rd_acc_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        regwrite_w_q, regwrite_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [18:0] result_w_q, result_w_d;

    logic        mem_op;
    logic        in_access;
    logic        timeout;
    logic [18:0] load_data;

    assign mem_op    = MemWriteM | ResultSrcM;
    assign in_access = (state_q == ACCESS);
    // mem_ready beats the timeout when both land on the 16th cycle
    assign timeout   = in_access & ~mem_ready & (tmo_q == 4'd15);
    assign load_data = byte_q ? {11'b0, mem_rdata[7:0]} : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            we_q           <= 1'b0;
            byte_q         <= 1'b0;
            regwrite_acc_q <= 1'b0;
            rd_acc_q       <= '0;
            tmo_q          <= '0;
            regwrite_w_q   <= 1'b0;
            rd_w_q         <= '0;
            result_w_q     <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            we_q           <= we_d;
            byte_q         <= byte_d;
            regwrite_acc_q <= regwrite_acc_d;
            rd_acc_q       <= rd_acc_d;
            tmo_q          <= tmo_d;
            regwrite_w_q   <= regwrite_w_d;
            rd_w_q         <= rd_w_d;
            result_w_q     <= result_w_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        we_d           = we_q;
        byte_d         = byte_q;
        regwrite_acc_d = regwrite_acc_q;
        rd_acc_d       = rd_acc_q;
        tmo_d          = tmo_q;
        regwrite_w_d   = regwrite_w_q;
        rd_w_d         = rd_w_q;
        result_w_d     = result_w_q;

        if (state_q == IDLE) begin
            if (mem_op) begin
                state_d        = ACCESS;
                addr_d         = ALUResultM;
                wdata_d        = Cant_ByteM ? {11'b0, WriteDataM[7:0]} : WriteDataM;
                we_d           = MemWriteM;
                byte_d         = Cant_ByteM;
                regwrite_acc_d = RegWriteM;
                rd_acc_d       = RDM;
                tmo_d          = 4'd0;
                regwrite_w_d   = 1'b0;
            end else begin
                regwrite_w_d = RegWriteM & (RDM != 5'd0);
                rd_w_d       = RDM;
                result_w_d   = ALUResultM;
            end
        end else begin
            if (mem_ready) begin
                state_d = IDLE;
                if (we_q) begin
                    regwrite_w_d = 1'b0;
                end else begin
                    regwrite_w_d = regwrite_acc_q & (rd_acc_q != 5'd0);
                    rd_w_d       = rd_acc_q;
                    result_w_d   = load_data;
                end
            end else if (timeout) begin
                state_d      = IDLE;
                regwrite_w_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 4'd1;
            end
        end
    end

    always_comb begin
        mem_req   = in_access;
        mem_we    = in_access & we_q;
        mem_byte  = byte_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_err   = timeout;
        RegWriteW = regwrite_w_q;
        RDW       = rd_w_q;
        ResultW   = result_w_q;
        StallM    = 1'b0;
        if (!reset) begin
            StallM = in_access ? (~mem_ready & ~timeout) : mem_op;
        end
    end

endmodule

// File: tb/tb_memory_writeback.sv
// tb/tb_memory_writeback.sv - scoreboard bench with ROM responder and random latency
module tb_memory_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0, Cant_ByteM = 1'b0;
    logic [4:0]  RDM = '0;
    logic [18:0] ALUResultM = '0, WriteDataM = '0;
    logic        mem_req, mem_we, mem_byte;
    logic [18:0] mem_addr, mem_wdata;
    logic [18:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [18:0] ResultW;
    logic        StallM, mem_err;

    memory_writeback dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Cant_ByteM(Cant_ByteM), .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .StallM(StallM), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        full;
        logic        rw;
        logic [4:0]  rd;
        logic [18:0] res;
    } wb_t;

    typedef struct {
        logic [18:0] addr;
        logic        we;
        logic        bt;
        logic [18:0] wdata;
        int          lat;
    } mem_t;

    wb_t  exp_wb[$];
    mem_t exp_mem[$];
    int   lat_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by loads; address 100 holds 19'h1ABCD
    function automatic logic [18:0] rom(input logic [18:0] a);
        logic [18:0] t;
        t = a - 19'd100;
        return 19'h1ABCD ^ (t * 19'd7919);
    endfunction

    // Responder: raises mem_ready on the lat-th cycle of each access
    int rcnt = 0;
    int cur_lat = 1;
    always @(negedge clk) begin
        if (mem_req) begin
            if (rcnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            rcnt++;
            mem_ready = (rcnt == cur_lat);
        end else begin
            rcnt = 0;
            mem_ready = 1'b0;
        end
        mem_rdata = rom(mem_addr);
    end

    // Monitor: samples between the falling and the next rising edge
    bit          wb_pending = 0;
    bit          prev_stall = 0;
    int          acc_cnt = 0;
    logic [4:0]  hold_rd = '0;
    logic [18:0] hold_res = '0;
    always @(negedge clk) begin
        wb_t  e;
        mem_t m;
        bit   done_ok, tmo;
        #3;
        if (reset) begin
            wb_pending = 0; prev_stall = 0; acc_cnt = 0; hold_rd = '0; hold_res = '0;
        end else begin
            if (wb_pending) begin
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_underflow: retirement with no expected entry at %0t", $time);
                end else begin
                    e = exp_wb.pop_front();
                    chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, e.rw});
                    if (e.full) begin
                        chk("RDW", {27'b0, RDW}, {27'b0, e.rd});
                        chk("ResultW", {13'b0, ResultW}, {13'b0, e.res});
                    end
                end
                hold_rd = RDW; hold_res = ResultW;
            end
            if (prev_stall) begin
                chk("bubble_RegWriteW", {31'b0, RegWriteW}, 32'd0);
                chk("hold_RDW", {27'b0, RDW}, {27'b0, hold_rd});
                chk("hold_ResultW", {13'b0, ResultW}, {13'b0, hold_res});
            end
            if (mem_req) begin
                acc_cnt++;
                if (exp_mem.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_unexpected: mem_req with no expected access at %0t", $time);
                end else begin
                    m = exp_mem[0];
                    chk("mem_addr", {13'b0, mem_addr}, {13'b0, m.addr});
                    chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                    chk("mem_byte", {31'b0, mem_byte}, {31'b0, m.bt});
                    if (m.we) chk("mem_wdata", {13'b0, mem_wdata}, {13'b0, m.wdata});
                    done_ok = (acc_cnt == m.lat);
                    tmo = (m.lat > 16) && (acc_cnt == 16);
                    chk("mem_err", {31'b0, mem_err}, {31'b0, tmo});
                    chk("StallM_access", {31'b0, StallM}, {31'b0, !(done_ok || tmo)});
                    if (done_ok || tmo) begin
                        void'(exp_mem.pop_front());
                        acc_cnt = 0;
                    end
                end
            end else begin
                chk("mem_we_idle", {31'b0, mem_we}, 32'd0);
                chk("mem_err_idle", {31'b0, mem_err}, 32'd0);
                chk("StallM_idle", {31'b0, StallM}, {31'b0, MemWriteM | ResultSrcM});
            end
            wb_pending = !StallM;
            prev_stall = StallM;
        end
    end

    task automatic drive(input logic rw, mw, rs, cb, input logic [4:0] rd,
                         input logic [18:0] alu, wd);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Cant_ByteM = cb;
        RDM = rd; ALUResultM = alu; WriteDataM = wd;
    endtask

    // Called at a falling edge; returns at the falling edge after the op retires
    task automatic issue(input logic rw, mw, rs, cb, input logic [4:0] rd,
                         input logic [18:0] alu, wd, input int lat);
        wb_t  e;
        mem_t m;
        logic [18:0] r;
        logic st;
        int n;
        drive(rw, mw, rs, cb, rd, alu, wd);
        e.full = 1'b1; e.rw = rw && (rd != 5'd0); e.rd = rd; e.res = alu;
        if (mw || rs) begin
            m.addr = alu; m.we = mw; m.bt = cb;
            m.wdata = cb ? {11'b0, wd[7:0]} : wd; m.lat = lat;
            exp_mem.push_back(m);
            lat_q.push_back(lat);
            if (mw || lat > 16) begin
                e.full = 1'b0; e.rw = 1'b0;
            end else begin
                r = rom(alu);
                e.res = cb ? {11'b0, r[7:0]} : r;
            end
        end
        exp_wb.push_back(e);
        n = 0;
        do begin
            #3 st = StallM;
            @(negedge clk);
            n++;
        end while (st && n < 40);
        if (st) begin
            checks++; errors++;
            $display("FAIL issue_timeout: still stalled after %0d cycles at %0t", n, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #400000;
        checks++; errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        mem_t m;
        logic [1:0] kind;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 19'd55, 19'd66);
        #3;
        chk("rst_RegWriteW", {31'b0, RegWriteW}, 32'd0);
        chk("rst_RDW", {27'b0, RDW}, 32'd0);
        chk("rst_ResultW", {13'b0, ResultW}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_byte", {31'b0, mem_byte}, 32'd0);
        chk("rst_mem_addr", {13'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {13'b0, mem_wdata}, 32'd0);
        chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
        chk("rst_StallM", {31'b0, StallM}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 19'd2, 19'd0, 0);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 19'd100, 19'd0, 3);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 19'd7, 19'h12345, 1);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 19'd200, 19'd0, 20);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 19'd77, 19'd0, 0);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd10, 19'd300, 19'd0, 16);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 19'd301, 19'd0, 17);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 19'd302, 19'd0, 2);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 19'd9, 19'd0, 0);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 19'd303, 19'd0, 1);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 19'd50, 19'h7ABCD, 4);
        issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd13, 19'd51, 19'd0, 1);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 19'd40, 19'd0);
        m.addr = 19'd40; m.we = 1'b0; m.bt = 1'b0; m.wdata = 19'd0; m.lat = 10;
        exp_mem.push_back(m);
        lat_q.push_back(10);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_RegWriteW", {31'b0, RegWriteW}, 32'd0);
        chk("midrst_RDW", {27'b0, RDW}, 32'd0);
        chk("midrst_ResultW", {13'b0, ResultW}, 32'd0);
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_mem_addr", {13'b0, mem_addr}, 32'd0);
        chk("midrst_mem_err", {31'b0, mem_err}, 32'd0);
        chk("midrst_StallM", {31'b0, StallM}, 32'd0);
        exp_mem.delete();
        exp_wb.delete();
        lat_q.delete();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 19'd0, 19'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd14, 19'd100, 19'd0, 2);

        for (int i = 0; i < 150; i++) begin
            kind = 2'($urandom_range(0, 3));
            case (kind)
                2'd0, 2'd3: issue(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                                  5'($urandom_range(0, 31)), 19'($urandom), 19'($urandom), 0);
                2'd1: issue(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 31)), 19'($urandom), 19'($urandom),
                            int'($urandom_range(1, 18)));
                default: issue(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                               19'($urandom), 19'($urandom), int'($urandom_range(1, 18)));
            endcase
        end

        issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 19'd0, 19'd0, 0);
        #5;
        chk("wb_queue_drained", exp_wb.size(), 32'd0);
        chk("mem_queue_drained", exp_mem.size(), 32'd0);
        finish_run();
    end

endmodule

// File: doc/memory_writeback.md
MEMORY_WRITEBACK -- requirements
Module: memory_writeback

Interface
REQ-001 The block SHALL use one clock and one reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-002 The block SHALL have these M-stage inputs from execute: RegWriteM input 1, register write enable; MemWriteM input 1, store; ResultSrcM input 1, 0=ALU result, 1=load data; Cant_ByteM input 1, 1=byte access, 0=word access; RDM input 5, destination register; ALUResultM input 19, ALU result / memory address; WriteDataM input 19, store data.
REQ-003 The block SHALL have these data-memory handshake ports: mem_req output 1, request; mem_we output 1, write; mem_byte output 1, byte access; mem_addr output 19, address; mem_wdata output 19, write data; mem_rdata input 19, read data; mem_ready input 1, access complete.
REQ-004 The block SHALL have these writeback outputs: RegWriteW output 1, register write enable; RDW output 5, destination register; ResultW output 19, write value.
REQ-005 The block SHALL have these status outputs: StallM output 1, hold execute/M inputs stable; mem_err output 1, one-cycle timeout pulse.

Function
REQ-006 The block SHALL treat a memory op as (MemWriteM | ResultSrcM) and an ALU op as any other input.
REQ-007 The block SHALL use an FSM with states IDLE and ACCESS.
REQ-008 ALU op in IDLE: the next edge SHALL register ResultW=ALUResultM, RDW=RDM, RegWriteW=RegWriteM (latency 1) with StallM=0.
REQ-009 Memory op in IDLE: StallM SHALL be 1 combinationally; the next edge SHALL move to ACCESS and latch the address, data, we and byte fields; RegWriteW SHALL be 0 on that edge (bubble).
REQ-010 In ACCESS, mem_req SHALL be 1; mem_addr, mem_wdata, mem_we and mem_byte SHALL come from the latched fields and stay stable until completion.
REQ-011 In ACCESS, StallM SHALL be ~mem_ready.
REQ-012 In ACCESS with mem_ready=1, the edge SHALL return to IDLE and register writeback: load gives ResultW=mem_rdata (word) or {11'b0, mem_rdata[7:0]} (byte), RegWriteW=latched RegWriteM; store gives RegWriteW=0.
REQ-013 Byte store: mem_wdata SHALL be {11'b0, WriteDataM[7:0]} with mem_byte=1.
REQ-014 RegWriteW SHALL be forced to 0 whenever RDW is 0 (R0 is read-only).
REQ-015 A 4-bit timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ready.
REQ-016 On the 16th ACCESS cycle without mem_ready, the block SHALL pulse mem_err for 1 cycle, set StallM=0 that cycle, return to IDLE, and write no register (RegWriteW=0).
REQ-017 When mem_ready and the timeout occur in the same cycle, mem_ready SHALL win: normal completion, no mem_err.
REQ-018 Outside ACCESS, mem_req and mem_we SHALL be 0.
REQ-019 mem_req SHALL never be asserted for two back-to-back accesses without an intervening IDLE cycle.
REQ-020 RDW, ResultW and RegWriteW SHALL hold their values across stall cycles except where RegWriteW is forced to 0 by a bubble.

Reset
REQ-021 On reset asserted (asynchronous), the state SHALL go to IDLE immediately and RegWriteW, RDW, ResultW, mem_req, mem_we, mem_byte, mem_addr, mem_wdata, the timeout counter and mem_err SHALL all be 0.
REQ-022 With reset asserted, StallM SHALL be 0 regardless of the inputs.
REQ-023 Reset asserted mid-ACCESS SHALL abandon the access with no register write and no mem_err.
REQ-024 After reset releases, the first rising edge SHALL process the inputs normally.

Verification
REQ-025 ALU pass-through: RegWriteM=1, RDM=3, ALUResultM=2 (20/10), no memory op -> next edge RegWriteW=1, RDW=3, ResultW=2; StallM stays 0.
REQ-026 Word load: ResultSrcM=1, ALUResultM=100, RDM=5, mem_ready high on the 3rd ACCESS cycle with mem_rdata=19'h1ABCD -> mem_addr=100 for 3 cycles, then ResultW=19'h1ABCD and RegWriteW=1, with StallM high for 3 cycles before that.
REQ-027 Byte store: MemWriteM=1, Cant_ByteM=1, ALUResultM=7, WriteDataM=19'h12345, mem_ready on the 1st ACCESS cycle -> mem_we=1, mem_byte=1, mem_wdata=19'h00045, RegWriteW=0.
REQ-028 Timeout: load with mem_ready held 0 -> mem_err pulses on the 16th ACCESS cycle, RegWriteW stays 0, FSM returns to IDLE, and the next ALU op completes normally.
REQ-029 Reset mid-access: assert reset in the 2nd ACCESS cycle -> all outputs are 0 at once with no write; after release, a word load completes normally.
REQ-030 R0 guard: ALU op with RDM=0, RegWriteM=1, ALUResultM=9 -> RegWriteW=0.
